// File: rtl/mux_scan_sel.sv
// mux_scan_sel: registered N-to-1 channel mux with manual select or dwell-timed auto-scan.
module mux_scan_sel #(
  parameter int WIDTH    = 3,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      start,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      scan_done
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_EMIT, S_DONE} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] ch, ch_n, load_sel;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] chans [CHANNELS];
  logic [WIDTH-1:0] load_data;
  logic free, load;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign chans[i] = data_in[i*WIDTH +: WIDTH];
  end
  assign free      = !out_valid || out_ready;
  assign busy      = state != S_IDLE;
  assign scan_done = state == S_DONE;
  assign load_data = int'(load_sel) < CHANNELS ? chans[load_sel] : '0;
  // Dropping mode mid-scan wins over any pending scan load.
  always_comb begin
    state_n  = state;
    ch_n     = ch;
    cnt_n    = cnt;
    load     = 1'b0;
    load_sel = sel_in;
    case (state)
      S_IDLE:
        if (!mode) load = free;
        else if (start) begin
          state_n = S_DWELL;
          ch_n    = '0;
          cnt_n   = '0;
        end
      S_DWELL:
        if (!mode) state_n = S_IDLE;
        else if (cnt == CNT_W'(DWELL-1)) state_n = S_EMIT;
        else cnt_n = cnt + 1'b1;
      S_EMIT:
        if (!mode) state_n = S_IDLE;
        else if (free) begin
          load     = 1'b1;
          load_sel = ch;
          if (ch == SEL_W'(CHANNELS-1)) state_n = S_DONE;
          else begin
            state_n = S_DWELL;
            ch_n    = ch + 1'b1;
            cnt_n   = '0;
          end
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ch        <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ch        <= ch_n;
      cnt       <= cnt_n;
      out_valid <= load || (out_valid && !out_ready);
      if (load) begin
        out_data <= load_data;
        out_sel  <= load_sel;
      end
    end
  end
endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised, registered N-to-1 channel multiplexer. It generalises the 8-to-1 three-select-bit mux in width and channel count, and adds a registered output with a valid/ready handshake. Two modes are provided:
- Manual: the select input picks the channel, and the choice is registered.
- Auto-scan: on a start pulse the block steps through every channel once, holding each for a programmable dwell time before emitting it.

It sits between a bank of multi-bit sources and a single downstream consumer.

Parameters:
WIDTH, 3, bit width of each channel.
CHANNELS, 8, number of input channels (2..256).
SEL_W, 3, select width; must be >= clog2(CHANNELS).
DWELL, 4, cycles spent in DWELL per channel before emission (>= 1).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
data_in  input  CHANNELS*WIDTH  flattened channels; channel i = data_in[i*WIDTH +: WIDTH].
sel_in  input  SEL_W  manual channel select.
mode  input  1  0 = manual, 1 = auto-scan.
start  input  1  single-cycle request to begin a scan (mode=1 only).
out_data  output  WIDTH  registered selected data.
out_sel  output  SEL_W  channel index of out_data.
out_valid  output  1  out_data/out_sel hold an unconsumed item.
out_ready  input  1  consumer accepts the item when out_valid && out_ready.
busy  output  1  high in any state other than IDLE.
scan_done  output  1  one-cycle pulse after the last channel of a scan is emitted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; internal ch=0, cnt=0.
  - out_data=0, out_sel=0, out_valid=0, busy=0, scan_done=0.
  - Release is synchronous to clk; the first active edge after release sees IDLE.
- Slot free = !out_valid || out_ready. A load happens only when the slot is free.
- Load + consume in the same cycle: the new item replaces the old one and out_valid stays 1.
- Consume without load: out_valid -> 0; out_data/out_sel hold their last values.
- Manual mode (mode=0, state IDLE):
  - Every edge with the slot free: out_data <= channel[sel_in], out_sel <= sel_in, out_valid <= 1.
  - Latency: 1 cycle.
  - sel_in >= CHANNELS: out_data <= 0 and out_sel <= sel_in; the item is still emitted.
- States: IDLE, DWELL, EMIT, DONE.
  - IDLE: mode=1 && start -> DWELL, with ch=0, cnt=0. start is ignored when mode=0 or the state is not IDLE.
  - DWELL: if cnt==DWELL-1 -> EMIT, else cnt++. DWELL therefore lasts exactly DWELL cycles.
  - EMIT, slot free: load channel[ch] as sampled at that edge and set out_sel=ch.
    - If ch==CHANNELS-1 -> DONE.
    - Otherwise ch++, cnt=0 -> DWELL.
  - EMIT, slot not free: stay in EMIT (stall). No channel is ever skipped or duplicated.
  - DONE: scan_done=1 for exactly this cycle -> IDLE.
- Scan cadence without backpressure: DWELL+1 cycles per channel. The first item is valid DWELL+1 edges after the start edge.
- mode dropped to 0 during DWELL/EMIT: abort to IDLE at the next edge.
  - No further scan loads and no scan_done.
  - An already-held item stays valid until consumed.
  - Manual loads resume from the cycle after IDLE is entered.
- Manual loads are suppressed while busy=1.
- ch and cnt wrap cannot occur: ch is reset on every scan start.
- Reset mid-scan: the block returns to IDLE immediately and discards the held item (out_valid=0).

Test Plan:
- Manual, CHANNELS=8, WIDTH=3, channel i = i, out_ready=1, sel_in=1 then 6 -> out_data=1, out_sel=1 one cycle later, then out_data=6, out_sel=6; out_valid stays 1.
- Full scan, DWELL=4, channel i = 7-i, out_ready=1, start pulsed at edge 0:
  - Items 7,6,5,...,0 become valid after edges 5,10,...,40.
  - scan_done is high for the single cycle after edge 40; busy falls at edge 41.
- Backpressure: as the full scan, but out_ready=0 for 3 cycles while channel 2's item is held -> EMIT for channel 3 stalls. Every channel 0..7 still appears exactly once, in order; scan_done is delayed by 3 cycles.
- Abort: mode 1->0 after channel 3 is emitted, out_ready=1 -> no channel 4 item and no scan_done; busy=0 next edge; a manual sel_in=2 yields out_data=channel 2.
- Reset mid-scan: rst_n low asynchronously during DWELL of channel 5 -> out_valid, busy, out_data and out_sel are all 0 immediately. After release, a fresh start rescans from channel 0.
- Out-of-range select, CHANNELS=6, SEL_W=3, sel_in=7 -> out_data=0, out_sel=7, out_valid=1.
